reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Issue-side hazard controller for the core's architectural register file; replaces ad-hoc single-bit occupancy tracking between data-fetch and writeback.
- Tracks, per register, how many issued micro-ops still owe a write, and grants or stalls issue from the data-fetch/schedule stage.
- Decrements on writeback and on squash after a branch redirect; flags underflow as a sticky error.

Parameters:
NREGS, 17, number of tracked registers (GPRs plus one spare slot); bit i of every mask is register index i.
CNT_W, 2, width of each pending-write counter; max pending writes per register = 2**CNT_W-1.

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
issue_valid  input  1  data-fetch stage presents a micro-op.
issue_src_mask  input  NREGS  registers the micro-op reads.
issue_dst_mask  input  NREGS  registers the micro-op writes (includes stack pointer for push/pop/call/ret).
issue_ready  output  1  combinational grant; issue occurs when issue_valid && issue_ready.
wb_valid  input  1  writeback retires a micro-op this cycle.
wb_dst_mask  input  NREGS  registers written by the retiring micro-op.
squash_valid  input  1  an issued micro-op is killed before writeback.
squash_dst_mask  input  NREGS  destination mask of the killed micro-op.
busy  output  NREGS  registered; bit i = (counter i != 0).
idle  output  1  registered; all counters zero.
err_underflow  output  1  registered sticky; a decrement hit a zero counter.

Behaviour:
- State: NREGS counters cnt[i] of CNT_W bits, plus the err_underflow flop.
- Reset (async, any time, including mid-operation): all cnt = 0, busy = 0, idle = 1, err_underflow = 0. issue_ready then reflects zero counters, so it is 1 whenever no inputs block.
- issue_ready = !(any i: src[i] && cnt[i] != 0) && !(any i: dst[i] && cnt[i] == MAX).
  - RAW: stall while any source has a pending write.
  - WAW: allowed, because writes retire in order; stall only on counter saturation.
  - Combinational from registered cnt only. No same-cycle bypass from wb or squash: a register freed by writeback in cycle N is issuable in cycle N+1.
  - issue_ready does not depend on issue_valid.
- Per-register next-state: cnt[i]' = cnt[i] + inc[i] - wbdec[i] - sqdec[i], each term 0 or 1.
  - inc[i] = fire && dst[i].
  - Compute in CNT_W+1 bits. The result is never > MAX, because issue is gated on saturation.
- Simultaneous events on the same register:
  - Issue plus wb: net unchanged.
  - wb plus squash: net −2.
  - Issue plus wb plus squash: net −1.
- Underflow: if the total decrement exceeds cnt[i] + inc[i], clamp cnt[i]' to 0 and set err_underflow. It remains set until reset.
- busy and idle are updated from next-state, so both reflect cnt[i]' one cycle after the causing edge, consistent with cnt.
- A zero mask with a valid strobe is legal and is a no-op for counters. An issue with empty src and dst masks always gets issue_ready = 1.
- Latency: issue grant = 0 cycles (combinational). Counter update = 1 cycle.

Decomposition:
- Shared package sb_pkg holds:
  - NREGS and CNT_W defaults.
  - reg_mask_t typedef (logic[NREGS-1:0]).
  - Register index constants matching the core's GPR numbering (RAX=0, RCX=1, RDX=2, RBX=3, RSP=4, …, R15=15).
  - A helper function that builds a one-hot mask from an index.
- One sub-module is natural: sb_counter, the per-register counter with inc/dec/dec inputs, clamp, underflow pulse and nonzero output. It is instantiated NREGS times via generate.
- The top level does the ready reduction, underflow OR and idle reduction.

Test Plan:
1. Reset/idle: assert reset mid-run with cnt[RAX]=2 → same cycle: busy=0, idle=1, err_underflow=0; with src=1<<0 and issue_valid=1, issue_ready=1.
2. RAW stall: issue dst=1<<0 (RAX); next cycle present src=1<<0 → issue_ready=0. Pulse wb_valid with wb_dst_mask=1<<0 at cycle N → issue_ready=0 at N, 1 at N+1.
3. WAW/saturation: issue dst=1<<4 (RSP) three times → busy[4]=1, cnt=3; fourth issue with dst=1<<4 → issue_ready=0. One wb on RSP → issue_ready=1 next cycle.
4. Simultaneous: cnt[RBX]=1; same cycle issue dst=1<<3 and wb dst=1<<3 → cnt stays 1, busy[3]=1. Next cycle wb and squash on RBX with cnt=2 → cnt=0, idle=1.
5. Underflow: from idle, wb_valid with wb_dst_mask=1<<1 → cnt[1] stays 0, err_underflow=1 next cycle and remains 1 across subsequent normal traffic until reset.
6. Multi-register: issue src=0x0003, dst=0x0010 with all clear → granted; then src=0x0010 stalls, src=0x0001 granted; squash dst=0x0010 → busy=0 next cycle.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared definitions for the register scoreboard.
//   SB_NREGS / SB_CNT_W : default register count and pending-write counter width
//   reg_mask_t          : one bit per tracked register, bit i = register index i
//   RAX..R15, SPARE     : register indices in the core's GPR numbering
//   sb_onehot()         : builds a single-register mask from an index
package sb_pkg;

    localparam int SB_NREGS = 17;
    localparam int SB_CNT_W = 2;

    typedef logic [SB_NREGS-1:0] reg_mask_t;

    localparam int unsigned RAX   = 0;
    localparam int unsigned RCX   = 1;
    localparam int unsigned RDX   = 2;
    localparam int unsigned RBX   = 3;
    localparam int unsigned RSP   = 4;
    localparam int unsigned RBP   = 5;
    localparam int unsigned RSI   = 6;
    localparam int unsigned RDI   = 7;
    localparam int unsigned R8    = 8;
    localparam int unsigned R9    = 9;
    localparam int unsigned R10   = 10;
    localparam int unsigned R11   = 11;
    localparam int unsigned R12   = 12;
    localparam int unsigned R13   = 13;
    localparam int unsigned R14   = 14;
    localparam int unsigned R15   = 15;
    localparam int unsigned SPARE = 16;

    function automatic reg_mask_t sb_onehot(input int unsigned idx);
        return reg_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / squash bundle between the data-fetch stage, writeback
// and the register scoreboard.
//   master : the pipeline side; drives issue, writeback and squash strobes
//   slave  : the scoreboard; returns issue_ready and the status outputs
interface reg_scoreboard_if #(
    parameter int NREGS = 17
);
    logic             issue_valid;
    logic [NREGS-1:0] issue_src_mask;
    logic [NREGS-1:0] issue_dst_mask;
    logic             issue_ready;
    logic             wb_valid;
    logic [NREGS-1:0] wb_dst_mask;
    logic             squash_valid;
    logic [NREGS-1:0] squash_dst_mask;
    logic [NREGS-1:0] busy;
    logic             idle;
    logic             err_underflow;

    modport master (
        output issue_valid, issue_src_mask, issue_dst_mask,
        output wb_valid, wb_dst_mask,
        output squash_valid, squash_dst_mask,
        input  issue_ready, busy, idle, err_underflow
    );

    modport slave (
        input  issue_valid, issue_src_mask, issue_dst_mask,
        input  wb_valid, wb_dst_mask,
        input  squash_valid, squash_dst_mask,
        output issue_ready, busy, idle, err_underflow
    );
endinterface

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register.
//   clk, reset    : core clock, asynchronous active-high reset
//   inc           : an issued micro-op will write this register
//   wb_dec        : a micro-op writing this register retired
//   sq_dec        : a micro-op writing this register was squashed
//   nonzero       : current count != 0 (from the register)
//   nonzero_next  : count after this cycle's update != 0
//   saturated     : current count == 2**CNT_W-1
//   underflow     : decrements exceed what is outstanding this cycle
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic wb_dec,
    input  logic sq_dec,
    output logic nonzero,
    output logic nonzero_next,
    output logic saturated,
    output logic underflow
);

    localparam logic [CNT_W:0] MAX = (CNT_W+1)'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   dec;

    // One extra bit of headroom so cnt+inc never wraps before the
    // decrements are compared against it.
    always_comb begin
        sum          = {1'b0, cnt_reg} + (CNT_W+1)'(inc);
        dec          = (CNT_W+1)'(wb_dec) + (CNT_W+1)'(sq_dec);
        underflow    = (dec > sum);
        cnt_next     = underflow ? '0 : CNT_W'(sum - dec);
        nonzero_next = (cnt_next != '0);
    end

    assign nonzero   = (cnt_reg != '0);
    assign saturated = ({1'b0, cnt_reg} == MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side hazard controller for the architectural register file.
// Counts outstanding writes per register and stalls issue on RAW hazards
// and on counter saturation; writes retire in order, so WAW is allowed.
//   clk, reset : core clock, asynchronous active-high reset
//   sb (slave) : issue_valid/src/dst -> issue_ready (combinational)
//                wb_valid/wb_dst_mask, squash_valid/squash_dst_mask
//                busy, idle, err_underflow (registered status)
module reg_scoreboard
    import sb_pkg::*;
#(
    parameter int NREGS = SB_NREGS,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_scoreboard_if.slave      sb
);

    logic             fire;
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] wb_vec;
    logic [NREGS-1:0] sq_vec;
    logic [NREGS-1:0] nz_vec;
    logic [NREGS-1:0] nz_next_vec;
    logic [NREGS-1:0] sat_vec;
    logic [NREGS-1:0] uf_vec;

    logic [NREGS-1:0] busy_reg;
    logic             idle_reg;
    logic             err_reg;

    // Grant depends only on registered counts: a register freed by
    // writeback this cycle becomes issuable next cycle.
    assign sb.issue_ready = ~(|(sb.issue_src_mask & nz_vec))
                          & ~(|(sb.issue_dst_mask & sat_vec));

    assign fire    = sb.issue_valid & sb.issue_ready;
    assign inc_vec = sb.issue_dst_mask  & {NREGS{fire}};
    assign wb_vec  = sb.wb_dst_mask     & {NREGS{sb.wb_valid}};
    assign sq_vec  = sb.squash_dst_mask & {NREGS{sb.squash_valid}};

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
            sb_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk          (clk),
                .reset        (reset),
                .inc          (inc_vec[gi]),
                .wb_dec       (wb_vec[gi]),
                .sq_dec       (sq_vec[gi]),
                .nonzero      (nz_vec[gi]),
                .nonzero_next (nz_next_vec[gi]),
                .saturated    (sat_vec[gi]),
                .underflow    (uf_vec[gi])
            );
        end
    endgenerate

    // Status flops load from next-state so they track the counters exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= '0;
            idle_reg <= 1'b1;
            err_reg  <= 1'b0;
        end else begin
            busy_reg <= nz_next_vec;
            idle_reg <= ~(|nz_next_vec);
            err_reg  <= err_reg | (|uf_vec);
        end
    end

    assign sb.busy          = busy_reg;
    assign sb.idle          = idle_reg;
    assign sb.err_underflow = err_reg;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;
    import sb_pkg::*;

    localparam int NR = SB_NREGS;
    localparam int MAXC = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    reg_scoreboard_if #(.NREGS(NR)) sb_bus ();

    reg_scoreboard #(.NREGS(NR), .CNT_W(SB_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: integer pending-write counts per register.
    int m_cnt [NR];
    bit m_err;

    function automatic bit model_ready();
        for (int i = 0; i < NR; i++) begin
            if (sb_bus.issue_src_mask[i] && m_cnt[i] > 0) return 1'b0;
            if (sb_bus.issue_dst_mask[i] && m_cnt[i] >= MAXC) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        int nx [NR];
        bit uf;
        bit f;
        if (reset) begin
            for (int i = 0; i < NR; i++) m_cnt[i] <= 0;
            m_err <= 1'b0;
        end else begin
            uf = 1'b0;
            f  = sb_bus.issue_valid && model_ready();
            for (int i = 0; i < NR; i++) begin
                nx[i] = m_cnt[i]
                      + ((f && sb_bus.issue_dst_mask[i]) ? 1 : 0)
                      - ((sb_bus.wb_valid && sb_bus.wb_dst_mask[i]) ? 1 : 0)
                      - ((sb_bus.squash_valid && sb_bus.squash_dst_mask[i]) ? 1 : 0);
                if (nx[i] < 0) begin
                    nx[i] = 0;
                    uf = 1'b1;
                end
            end
            for (int i = 0; i < NR; i++) m_cnt[i] <= nx[i];
            m_err <= m_err | uf;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [NR-1:0] exp_busy;
        bit            exp_idle;
        exp_busy = '0;
        for (int i = 0; i < NR; i++) exp_busy[i] = (m_cnt[i] != 0);
        exp_idle = (exp_busy == '0);
        chk("ready", 32'(sb_bus.issue_ready), 32'(model_ready()));
        chk("busy",  32'(sb_bus.busy), 32'(exp_busy));
        chk("idle",  32'(sb_bus.idle), 32'(exp_idle));
        chk("err",   32'(sb_bus.err_underflow), 32'(m_err));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit iv, input reg_mask_t s, input reg_mask_t d,
                         input bit wv, input reg_mask_t wm,
                         input bit qv, input reg_mask_t qm);
        sb_bus.issue_valid     = iv;
        sb_bus.issue_src_mask  = s;
        sb_bus.issue_dst_mask  = d;
        sb_bus.wb_valid        = wv;
        sb_bus.wb_dst_mask     = wm;
        sb_bus.squash_valid    = qv;
        sb_bus.squash_dst_mask = qm;
    endtask

    task automatic quiet();
        drive(0, '0, '0, 0, '0, 0, '0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        quiet();
        #1 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk("rst_idle", 32'(sb_bus.idle), 32'd1);
        chk("rst_busy", 32'(sb_bus.busy), 32'd0);
        tick();

        // RAW stall on RAX, released the cycle after writeback
        drive(1, '0, sb_onehot(RAX), 0, '0, 0, '0);
        settle(); chk("raw_issue_rdy", 32'(sb_bus.issue_ready), 32'd1);
        tick();
        drive(1, sb_onehot(RAX), '0, 1, sb_onehot(RAX), 0, '0);
        settle(); chk("raw_stall_wb_cycle", 32'(sb_bus.issue_ready), 32'd0);
        tick();
        drive(1, sb_onehot(RAX), '0, 0, '0, 0, '0);
        settle(); chk("raw_release", 32'(sb_bus.issue_ready), 32'd1);
        tick();
        quiet(); tick();

        // Multi-register sources/destination
        drive(1, 17'h00003, 17'h00010, 0, '0, 0, '0);
        settle(); chk("multi_grant", 32'(sb_bus.issue_ready), 32'd1);
        tick();
        drive(1, 17'h00010, '0, 0, '0, 0, '0);
        settle(); chk("multi_stall", 32'(sb_bus.issue_ready), 32'd0);
        tick();
        drive(1, 17'h00001, '0, 0, '0, 0, '0);
        settle(); chk("multi_other", 32'(sb_bus.issue_ready), 32'd1);
        tick();
        drive(0, '0, '0, 0, '0, 1, 17'h00010);
        tick();
        quiet();
        settle(); chk("multi_squash_busy", 32'(sb_bus.busy), 32'd0);
        tick();

        // WAW up to saturation on RSP
        for (int k = 0; k < 3; k++) begin
            drive(1, '0, sb_onehot(RSP), 0, '0, 0, '0);
            settle(); chk("waw_grant", 32'(sb_bus.issue_ready), 32'd1);
            tick();
        end
        drive(1, '0, sb_onehot(RSP), 0, '0, 0, '0);
        settle();
        chk("sat_stall", 32'(sb_bus.issue_ready), 32'd0);
        chk("sat_busy4", 32'(sb_bus.busy[RSP]), 32'd1);
        tick();
        drive(1, '0, sb_onehot(RSP), 1, sb_onehot(RSP), 0, '0);
        settle(); chk("sat_wb_same", 32'(sb_bus.issue_ready), 32'd0);
        tick();
        drive(1, '0, sb_onehot(RSP), 0, '0, 0, '0);
        settle(); chk("sat_wb_next", 32'(sb_bus.issue_ready), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, '0, 1, sb_onehot(RSP), 0, '0);
            tick();
        end
        quiet();
        settle(); chk("sat_drained", 32'(sb_bus.idle), 32'd1);
        tick();

        // Simultaneous events on RBX
        drive(1, '0, sb_onehot(RBX), 0, '0, 0, '0); tick();
        drive(1, '0, sb_onehot(RBX), 1, sb_onehot(RBX), 0, '0); tick();
        quiet();
        settle(); chk("sim_iss_wb_busy", 32'(sb_bus.busy[RBX]), 32'd1);
        drive(1, '0, sb_onehot(RBX), 0, '0, 0, '0); tick();
        drive(0, '0, '0, 1, sb_onehot(RBX), 1, sb_onehot(RBX)); tick();
        quiet();
        settle();
        chk("sim_wb_sq_idle", 32'(sb_bus.idle), 32'd1);
        chk("sim_no_err", 32'(sb_bus.err_underflow), 32'd0);
        tick();

        // Underflow from idle, sticky across normal traffic
        drive(0, '0, '0, 1, sb_onehot(RCX), 0, '0); tick();
        quiet();
        settle();
        chk("uf_set", 32'(sb_bus.err_underflow), 32'd1);
        chk("uf_cnt0", 32'(sb_bus.busy[RCX]), 32'd0);
        drive(1, '0, sb_onehot(RAX), 0, '0, 0, '0); tick();
        drive(0, '0, '0, 1, sb_onehot(RAX), 0, '0); tick();
        quiet();
        settle(); chk("uf_sticky", 32'(sb_bus.err_underflow), 32'd1);
        tick();

        // Asynchronous reset mid-run with RAX count 2
        drive(1, '0, sb_onehot(RAX), 0, '0, 0, '0); tick(); tick();
        drive(1, sb_onehot(RAX), '0, 0, '0, 0, '0);
        settle(); chk("pre_rst_stall", 32'(sb_bus.issue_ready), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(sb_bus.busy), 32'd0);
        chk("arst_idle", 32'(sb_bus.idle), 32'd1);
        chk("arst_err", 32'(sb_bus.err_underflow), 32'd0);
        chk("arst_ready", 32'(sb_bus.issue_ready), 32'd1);
        tick();
        reset = 1'b0;
        quiet();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
